// File: rtl/syscall_print_unit_pkg.sv
// syscall_print_unit_pkg: service codes, FSM states and dispatch helper for the syscall print engine.
package syscall_print_unit_pkg;
  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, INT, HALTED} state_t;
  function automatic logic stall_code(input logic [31:0] v);
`ifdef SYSCALL_PRINT_CHAR_EN
    return v == SYS_PRINT_INT || v == SYS_PRINT_STR || v == SYS_PRINT_CHAR;
`else
    return v == SYS_PRINT_INT || v == SYS_PRINT_STR;
`endif
  endfunction
endpackage

// File: rtl/syscall_print_unit_if.sv
// syscall_print_unit_if: syscall request, memory read port, output stream and pipeline status.
interface syscall_print_unit_if #(parameter int ADDR_W = 32);
  logic              syscall_valid;
  logic [31:0]       v0;
  logic [31:0]       a0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_int;
  logic [31:0]       out_data;
  logic              stall;
  logic              busy;
  logic              halt;
  logic              trunc;
  modport master (
    input  syscall_valid, v0, a0, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_is_int, out_data, stall, busy, halt, trunc
  );
  modport slave (
    output syscall_valid, v0, a0, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_valid, out_is_int, out_data, stall, busy, halt, trunc
  );
endinterface

// File: rtl/syscall_print_unit_byte_sel.sv
// syscall_byte_sel: big-endian 4:1 byte mux with null-terminator flag.
module syscall_byte_sel (
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  output logic [7:0]  chr,
  output logic        is_null
);
  always_comb begin
    chr = sel == 2'd0 ? word[31:24] : sel == 2'd1 ? word[23:16] : sel == 2'd2 ? word[15:8] : word[7:0];
    is_null = chr == 8'h00;
  end
endmodule

// File: rtl/syscall_print_unit.sv
// syscall_print_unit: multi-cycle print_int/print_string/exit service engine that stalls the front end.
// Optional print_char service (v0=11) is enabled by defining SYSCALL_PRINT_CHAR_EN.
module syscall_print_unit
  import syscall_print_unit_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic rst_n,
  syscall_print_unit_if.master bus
);
  localparam int CW = $clog2(MAX_LEN + 1);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     count;
  logic [31:0]       a0_q;
  logic [31:0]       word;
  logic              is_int;
  logic              halt_q;
  logic              trunc_q;
  logic [7:0]        chr;
  logic              is_null;
  logic              at_max;
  logic              emit_ok;
  syscall_byte_sel u_sel (.word(word), .sel(ptr[1:0]), .chr(chr), .is_null(is_null));
  always_comb begin
    at_max         = count == CW'(MAX_LEN);
    emit_ok        = state == EMIT && !is_null && !at_max;
    bus.out_valid  = state == INT || emit_ok;
    bus.out_is_int = state == INT && is_int;
    bus.out_data   = state == INT ? (is_int ? a0_q : {24'b0, a0_q[7:0]}) : emit_ok ? {24'b0, chr} : '0;
    bus.mem_rd_en  = state == FETCH;
    bus.mem_addr   = state == FETCH ? {ptr[ADDR_W-1:2], 2'b00} : '0;
    bus.busy       = state != IDLE;
    bus.stall      = (state != IDLE && state != HALTED) || (bus.syscall_valid && state == IDLE && stall_code(bus.v0));
    bus.halt       = halt_q;
    bus.trunc      = trunc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      count   <= '0;
      a0_q    <= '0;
      word    <= '0;
      is_int  <= 1'b0;
      halt_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.syscall_valid) begin
          a0_q    <= bus.a0;
          trunc_q <= 1'b0;
          if (bus.v0 == SYS_PRINT_INT) begin
            is_int <= 1'b1;
            state  <= INT;
          end
`ifdef SYSCALL_PRINT_CHAR_EN
          else if (bus.v0 == SYS_PRINT_CHAR) begin
            is_int <= 1'b0;
            state  <= INT;
          end
`endif
          else if (bus.v0 == SYS_PRINT_STR) begin
            ptr   <= bus.a0[ADDR_W-1:0];
            count <= '0;
            state <= FETCH;
          end else if (bus.v0 == SYS_EXIT) begin
            halt_q <= 1'b1;
            state  <= HALTED;
          end
        end
        INT: if (bus.out_ready) state <= IDLE;
        FETCH: state <= WAIT;
        WAIT: begin
          word  <= bus.mem_rdata;
          state <= EMIT;
        end
        EMIT: if (is_null) state <= IDLE;
        else if (at_max) begin
          trunc_q <= 1'b1;
          state   <= IDLE;
        end else if (bus.out_ready) begin
          // leaving the last byte of a word needs a fresh fetch
          ptr   <= ptr + ADDR_W'(1);
          count <= count + CW'(1);
          state <= ptr[1:0] == 2'd3 ? FETCH : EMIT;
        end
        default: ;
      endcase
    end
  end
endmodule
